// File: rtl/mul4_pkg.sv
// Shared constants and types for the mul4 candidate tournament sequencer.
// Lane i of every word is one test case: a = i[3:2], b = i[1:0].
package mul4_pkg;

    localparam logic [15:0] STIM_A1 = 16'hFF00;
    localparam logic [15:0] STIM_A0 = 16'hF0F0;
    localparam logic [15:0] STIM_B1 = 16'hCCCC;
    localparam logic [15:0] STIM_B0 = 16'hAAAA;

    // GOLDEN[p] is product bit p across all 16 lanes
    localparam logic [15:0] GOLDEN [4] = '{16'hA0A0, 16'h6AC0, 16'h4C00, 16'h8000};

    localparam int              SCORE_W   = 7;
    localparam logic [SCORE_W-1:0] MAX_SCORE = 7'd64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SCORE,
        ST_UPDATE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mul4_tournament_ctrl_if.sv
// Candidate-pool and selection-side bus of the tournament sequencer.
// slave = sequencer side, master = pool/selection side.
interface mul4_tournament_ctrl_if
    import mul4_pkg::*;
#(
    parameter int NUM_CAND = 4
);
    localparam int CW = $clog2(NUM_CAND);

    logic                start;
    logic                abort;
    logic [15:0]         a1, a0, b1, b0;
    logic [CW-1:0]       cand_sel;
    logic [15:0]         y3, y2, y1, y0;
    logic                busy;
    logic                score_valid;
    logic [CW-1:0]       score_idx;
    logic [SCORE_W-1:0]  score;
    logic                done;
    logic [CW-1:0]       winner_idx;
    logic [SCORE_W-1:0]  winner_score;
    logic                perfect;

    modport slave (
        input  start, abort, y3, y2, y1, y0,
        output a1, a0, b1, b0, cand_sel, busy, score_valid, score_idx, score,
               done, winner_idx, winner_score, perfect
    );

    modport master (
        output start, abort, y3, y2, y1, y0,
        input  a1, a0, b1, b0, cand_sel, busy, score_valid, score_idx, score,
               done, winner_idx, winner_score, perfect
    );

endinterface

// File: rtl/mul4_word_scorer.sv
// Counts matching bit lanes between one candidate output word and its golden word.
module mul4_word_scorer (
    input  logic [15:0] i_y,
    input  logic [15:0] i_g,
    output logic [4:0]  o_count
);

    logic [15:0] w_match;

    assign w_match = ~(i_y ^ i_g);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < 16; i++) begin
            o_count = o_count + {4'b0000, w_match[i]};
        end
    end

endmodule

// File: rtl/mul4_tournament_ctrl.sv
// Scores NUM_CAND mul4 candidates through one shared datapath and reports the best.
// state  | meaning
// IDLE   | waiting for start, stimulus words at 0
// SETTLE | candidate mux settling after a cand_sel change
// SCORE  | 4 phases, one product word per cycle into the accumulator
// UPDATE | publish score, update winner, step to next candidate
// DONE   | tournament end pulse, perfect flag latched
module mul4_tournament_ctrl
    import mul4_pkg::*;
#(
    parameter int NUM_CAND      = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    mul4_tournament_ctrl_if.slave bus
);

    localparam int CW = $clog2(NUM_CAND);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

    state_t              r_state, w_next;
    logic [CW-1:0]       r_cand_sel, r_winner_idx;
    logic [SCORE_W-1:0]  r_acc, r_winner_score;
    logic                r_perfect;
    logic [1:0]          r_phase;
    logic [SW-1:0]       r_settle_cnt;
    logic [15:0]         w_y_sel;
    logic [4:0]          w_pop;
    logic                w_last_cand;

    assign w_last_cand = (r_cand_sel == CW'(NUM_CAND - 1));

    always_comb begin
        case (r_phase)
            2'd0:    w_y_sel = bus.y0;
            2'd1:    w_y_sel = bus.y1;
            2'd2:    w_y_sel = bus.y2;
            default: w_y_sel = bus.y3;
        endcase
    end

    mul4_word_scorer u_scorer (
        .i_y     (w_y_sel),
        .i_g     (GOLDEN[r_phase]),
        .o_count (w_pop)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (bus.abort) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   if (bus.start) w_next = ST_SETTLE;
                ST_SETTLE: if (r_settle_cnt == '0) w_next = ST_SCORE;
                ST_SCORE:  if (r_phase == 2'd3) w_next = ST_UPDATE;
                ST_UPDATE: w_next = w_last_cand ? ST_DONE : ST_SETTLE;
                ST_DONE:   w_next = ST_IDLE;
                default:   w_next = ST_IDLE;
            endcase
        end
    end

    // Abort freezes every register so winner_* keep their partial values
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cand_sel     <= '0;
            r_winner_idx   <= '0;
            r_acc          <= '0;
            r_winner_score <= '0;
            r_perfect      <= 1'b0;
            r_phase        <= '0;
            r_settle_cnt   <= '0;
        end else if (!bus.abort) begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_cand_sel     <= '0;
                        r_acc          <= '0;
                        r_winner_idx   <= '0;
                        r_winner_score <= '0;
                        r_perfect      <= 1'b0;
                        r_phase        <= '0;
                        r_settle_cnt   <= SETTLE_LOAD;
                    end
                end
                ST_SETTLE: begin
                    if (r_settle_cnt != '0) r_settle_cnt <= r_settle_cnt - SW'(1);
                end
                ST_SCORE: begin
                    r_acc   <= r_acc + {2'b00, w_pop};
                    r_phase <= r_phase + 2'd1;
                end
                ST_UPDATE: begin
                    if (r_acc > r_winner_score) begin
                        r_winner_idx   <= r_cand_sel;
                        r_winner_score <= r_acc;
                    end
                    if (!w_last_cand) begin
                        r_cand_sel   <= r_cand_sel + CW'(1);
                        r_acc        <= '0;
                        r_settle_cnt <= SETTLE_LOAD;
                    end
                end
                ST_DONE: r_perfect <= (r_winner_score == MAX_SCORE);
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.busy         = (r_state != ST_IDLE);
        bus.a1           = bus.busy ? STIM_A1 : 16'h0000;
        bus.a0           = bus.busy ? STIM_A0 : 16'h0000;
        bus.b1           = bus.busy ? STIM_B1 : 16'h0000;
        bus.b0           = bus.busy ? STIM_B0 : 16'h0000;
        bus.cand_sel     = r_cand_sel;
        bus.score_valid  = (r_state == ST_UPDATE) && !bus.abort;
        bus.score        = bus.score_valid ? r_acc : '0;
        bus.score_idx    = bus.score_valid ? r_cand_sel : '0;
        bus.done         = (r_state == ST_DONE) && !bus.abort;
        bus.winner_idx   = r_winner_idx;
        bus.winner_score = r_winner_score;
        bus.perfect      = r_perfect;
    end

endmodule

// File: tb/tb_mul4_tournament_ctrl.sv
// Directed bench for mul4_tournament_ctrl: scoreboard of per-candidate scores
// plus winner, timing, abort and reset checks.
module tb_mul4_tournament_ctrl;
    import mul4_pkg::*;

    typedef struct packed {
        logic [1:0] idx;
        logic [6:0] sc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mul4_tournament_ctrl_if #(.NUM_CAND(4)) bus ();

    mul4_tournament_ctrl #(.NUM_CAND(4), .SETTLE_CYCLES(1)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    logic [15:0] cand_y [4][4];
    logic [15:0] gold   [4];
    exp_t        exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          done_seen = 0;

    always_comb begin
        bus.y0 = cand_y[bus.cand_sel][0];
        bus.y1 = cand_y[bus.cand_sel][1];
        bus.y2 = cand_y[bus.cand_sel][2];
        bus.y3 = cand_y[bus.cand_sel][3];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_score(input int c);
        int s = 0;
        for (int w = 0; w < 4; w++)
            for (int b = 0; b < 16; b++)
                if (cand_y[c][w][b] == gold[w][b]) s++;
        return s;
    endfunction

    // kind: 0 golden, 1 all-zero, 2 all-ones, 3 inverted golden
    task automatic set_cand(input int c, input int kind);
        for (int w = 0; w < 4; w++) begin
            case (kind)
                0:       cand_y[c][w] = gold[w];
                1:       cand_y[c][w] = 16'h0000;
                2:       cand_y[c][w] = 16'hFFFF;
                default: cand_y[c][w] = ~gold[w];
            endcase
        end
    endtask

    task automatic push_expected(input int upto);
        exp_t e;
        int   s;
        for (int c = 0; c < upto; c++) begin
            s     = model_score(c);
            e.idx = 2'(c);
            e.sc  = 7'(s);
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic run(input int exp_idx, input int exp_score, input int exp_perf, input bit mid_start);
        int n = 0;
        int d0;
        bit got = 0;
        push_expected(4);
        pulse_start();
        d0 = done_seen;
        while (n < 60 && !got) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk("busy_after_start", bus.busy, 1);
                chk("stim_a1", bus.a1, 16'hFF00);
                chk("stim_a0", bus.a0, 16'hF0F0);
                chk("stim_b1", bus.b1, 16'hCCCC);
                chk("stim_b0", bus.b0, 16'hAAAA);
            end
            if (mid_start && n == 8)  bus.start = 1'b1;
            if (mid_start && n == 9)  bus.start = 1'b0;
            if (bus.done === 1'b1) got = 1;
        end
        chk("done_cycle", n, 25);
        @(negedge clk);
        chk("busy_after_done", bus.busy, 0);
        chk("stim_idle", bus.a1, 0);
        chk("winner_idx", bus.winner_idx, exp_idx);
        chk("winner_score", bus.winner_score, exp_score);
        chk("perfect", bus.perfect, exp_perf);
        chk("sb_drained", exp_q.size(), 0);
        repeat (10) @(negedge clk);
        chk("done_count", done_seen - d0, 1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0) begin
            if (bus.done === 1'b1) done_seen++;
            if (bus.score_valid === 1'b1) begin
                chk("sb_nonempty", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("score_idx", bus.score_idx, e.idx);
                    chk("score", bus.score, e.sc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d0;
        int p;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        for (int i = 0; i < 16; i++) begin
            p = (i >> 2) * (i & 3);
            for (int k = 0; k < 4; k++) gold[k][i] = p[k];
        end
        for (int c = 0; c < 4; c++) set_cand(c, 0);

        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_score_valid", bus.score_valid, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_cand_sel", bus.cand_sel, 0);
        chk("rst_score", bus.score, 0);
        chk("rst_score_idx", bus.score_idx, 0);
        chk("rst_winner_idx", bus.winner_idx, 0);
        chk("rst_winner_score", bus.winner_score, 0);
        chk("rst_perfect", bus.perfect, 0);
        chk("rst_a1", bus.a1, 0);
        chk("rst_b0", bus.b0, 0);
        rst = 1'b0;
        @(negedge clk);

        // all golden
        run(0, 64, 1, 0);

        // only candidate 2 golden
        set_cand(0, 1); set_cand(1, 1); set_cand(2, 0); set_cand(3, 1);
        run(2, 64, 1, 0);

        // abort in candidate 2's SCORE window (cycles 14..17)
        set_cand(0, 1); set_cand(1, 0); set_cand(2, 0); set_cand(3, 1);
        push_expected(2);
        pulse_start();
        d0 = done_seen;
        for (n = 1; n <= 15; n++) @(negedge clk);
        bus.abort = 1'b1;
        @(posedge clk);
        #1 bus.abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", bus.busy, 0);
        repeat (30) @(negedge clk);
        chk("abort_no_done", done_seen - d0, 0);
        chk("abort_winner_idx", bus.winner_idx, 1);
        chk("abort_winner_score", bus.winner_score, 64);
        chk("abort_perfect", bus.perfect, 0);
        chk("abort_sb_drained", exp_q.size(), 0);

        // inverted / ones / ones / zero, with a start pulse while busy
        set_cand(0, 3); set_cand(1, 2); set_cand(2, 2); set_cand(3, 1);
        run(3, 50, 0, 1);

        // tie between candidates 1 and 3
        set_cand(0, 3); set_cand(1, 1); set_cand(2, 3); set_cand(3, 1);
        run(1, 50, 0, 0);

        // reset in candidate 1's SETTLE cycle (cycle 7)
        for (int c = 0; c < 4; c++) set_cand(c, 0);
        push_expected(4);
        pulse_start();
        for (n = 1; n <= 7; n++) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_cand_sel", bus.cand_sel, 0);
        chk("midrst_a1", bus.a1, 0);
        chk("midrst_winner_score", bus.winner_score, 0);
        chk("midrst_score_valid", bus.score_valid, 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run(0, 64, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul4_tournament_ctrl.md
# mul4_tournament_ctrl

Sequencer that scores a set of evolved 2x2-bit vector-multiplier candidates against the golden product. It shares one scoring datapath among NUM_CAND candidates and reports the tournament winner. The block drives the bit-parallel stimulus words, steps an external candidate-select mux, and accumulates per-candidate bit-match counts over 4 cycles. It sits between the candidate pool (combinational mul4 individuals behind a mux) and the selection logic.

## Interface
- NUM_CAND, 4: number of candidates; must be at least 2.
- SETTLE_CYCLES, 1: wait cycles after each cand_sel change before sampling; must be at least 1.
- CW = $clog2(NUM_CAND): derived; not overridable.

- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  begins a tournament when sampled in IDLE.
- abort  in  1  synchronous abort to IDLE; done does not fire.
- a1, a0, b1, b0  out  16 each  stimulus words to the candidates.
- cand_sel  out  CW  candidate index driven to the external mux.
- y3, y2, y1, y0  in  16 each  outputs of the selected candidate.
- busy  out  1  high from the start-accept cycle until done.
- score_valid  out  1  one-cycle pulse per scored candidate.
- score_idx  out  CW  candidate index, qualified by score_valid.
- score  out  7  bit-match count 0..64, qualified by score_valid.
- done  out  1  one-cycle pulse at tournament end.
- winner_idx  out  CW  best candidate; held until the next start.
- winner_score  out  7  best score; held until the next start.
- perfect  out  1  winner_score == 64; held until the next start.

## Operation
- Each bit lane i (0..15) is one test case: a = i[3:2], b = i[1:0].
- Stimulus words are constant: a1 = 16'hFF00, a0 = 16'hF0F0, b1 = 16'hCCCC, b0 = 16'hAAAA.
- Golden product words: G3 = 16'h8000, G2 = 16'h4C00, G1 = 16'h6AC0, G0 = 16'hA0A0.
- FSM states: IDLE, SETTLE, SCORE, UPDATE, DONE.
- IDLE: when start = 1, do the following and go to SETTLE:
  - set cand_sel = 0;
  - clear the accumulator;
  - clear winner_score to 0, winner_idx to 0, perfect to 0.
- SETTLE: stay SETTLE_CYCLES cycles, then go to SCORE.
- SCORE: 4 cycles, with phase p = 0..3.
  - Each cycle, acc += popcount(~(y_p ^ G_p)).
  - Phase p uses y0/G0 first, then y1/G1, y2/G2, y3/G3.
- UPDATE: 1 cycle.
  - score_valid = 1, score = acc, score_idx = cand_sel.
  - If acc > winner_score (strictly greater), load winner_idx and winner_score. Ties keep the lower index.
  - On the last candidate, go to DONE.
  - Otherwise increment cand_sel, clear acc, and go to SETTLE.
- DONE: 1 cycle; done = 1, perfect is updated, then go to IDLE.
- start is ignored outside IDLE.
- abort has priority over every transition except reset:
  - go to IDLE and drop busy;
  - winner_* keeps its partial values;
  - no score_valid or done in that cycle.
- Arithmetic:
  - per-word popcount is 5 bits (0..16);
  - accumulator is 7 bits and saturates naturally at 64;
  - no overflow is possible.

## Timing
- Reset values:
  - all stimulus outputs = 0;
  - cand_sel = 0, busy = 0, score_valid = 0, done = 0;
  - score = 0, score_idx = 0;
  - winner_idx = 0, winner_score = 0, perfect = 0;
  - FSM in IDLE.
- Stimulus words hold their constants whenever busy = 1, and are 0 in IDLE.
- y_p is sampled at the rising edge that ends each SCORE cycle.
- Candidates must be combinational within one clock period plus SETTLE_CYCLES.
- Per-candidate latency is SETTLE_CYCLES + 5 cycles.
- done asserts NUM_CAND*(SETTLE_CYCLES+5)+1 cycles after the start-accept edge. That is 25 cycles with the defaults.
- busy falls in the cycle after done; a new start is accepted in that same cycle.
- rst mid-tournament: immediate return to all reset values; no pulses are emitted.

## Structure
- mul4_pkg holds:
  - the stimulus constants STIM_A1, STIM_A0, STIM_B1, STIM_B0;
  - GOLDEN[4];
  - SCORE_W = 7, MAX_SCORE = 64;
  - the state_t enum.
- One sub-module, mul4_word_scorer: combinational popcount of ~(y ^ g) over 16 bits, 5-bit output. It is instantiated once and muxed by phase.

## Test plan
- All candidates return the golden words -> every score = 64; winner_idx = 0; perfect = 1; done at cycle 25.
- Candidate 2 golden, others all-zero -> scores 50, 50, 64, 50; winner_idx = 2; winner_score = 64.
- Candidate 0 returns ~golden, candidate 3 all-zero, others all-ones -> scores 0, 14, 14, 50; winner_idx = 3; perfect = 0.
- Tie: candidates 1 and 3 both all-zero, others ~golden -> winner_idx = 1, winner_score = 50.
- start pulsed while busy -> ignored; exactly one done.
- abort during candidate 2's SCORE -> busy drops next cycle, no done; winner_* reflects candidates 0–1 only.
- rst asserted mid-SETTLE -> all outputs return to their reset values immediately; the next start runs a full 25-cycle tournament.
